param_scfifo: RTL

//  Parametrised single-clock FIFO: generic successor to the fixed 16x256 scfifo.

---
 rtl/param_scfifo_pkg.sv | 34 +++
 rtl/param_scfifo_dpram.sv | 27 ++
 rtl/param_scfifo.sv | 123 ++++++++++++
 3 files changed

// File: rtl/param_scfifo_pkg.sv
// Shared defaults, mode codes and status-flag decode for the parametrised single-clock FIFO.
package param_scfifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH       = 16;
    localparam int unsigned DEF_ADDR_WIDTH       = 8;
    localparam int unsigned DEF_ALMOST_FULL_VAL  = 240;
    localparam int unsigned DEF_ALMOST_EMPTY_VAL = 16;

    localparam int unsigned SHOW_AHEAD_OFF = 0;
    localparam int unsigned SHOW_AHEAD_ON  = 1;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } fifo_flags_t;

    // Status flags as a pure function of the fill count.
    function automatic fifo_flags_t decode_flags(
        input int unsigned count,
        input int unsigned depth,
        input int unsigned af_val,
        input int unsigned ae_val
    );
        fifo_flags_t f;
        f.empty        = (count == 0);
        f.full         = (count == depth);
        f.almost_empty = (count < ae_val);
        f.almost_full  = (count >= af_val);
        return f;
    endfunction

endpackage

// File: rtl/param_scfifo_dpram.sv
// Simple dual-port storage array: one synchronous write port, one asynchronous read port.
module param_scfifo_dpram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset so the array maps onto block or LUT RAM.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_scfifo.sv
// Parametrised single-clock FIFO with exact fill count, almost flags, sticky error flags
// and a choice of registered (1-cycle) or show-ahead read data.
module param_scfifo
    import param_scfifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int unsigned ALMOST_FULL_VAL  = DEF_ALMOST_FULL_VAL,
    parameter int unsigned ALMOST_EMPTY_VAL = DEF_ALMOST_EMPTY_VAL,
    parameter int unsigned SHOW_AHEAD       = SHOW_AHEAD_OFF
) (
    input  logic                  clock,
    input  logic                  aclr,
    input  logic                  sclr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wrreq,
    input  logic                  rdreq,
    output logic [DATA_WIDTH-1:0] q,
    output logic [ADDR_WIDTH:0]   usedw,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    localparam fifo_flags_t FLAGS_CLR =
        decode_flags(0, DEPTH, ALMOST_FULL_VAL, ALMOST_EMPTY_VAL);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         usedw_nxt;
    logic [DATA_WIDTH-1:0] rdata;
    fifo_flags_t           flags;
    logic                  wr_ok;
    logic                  rd_ok;

    // A write into a full FIFO is only accepted when a read frees a slot in the same cycle.
    assign rd_ok = rdreq & ~flags.empty;
    assign wr_ok = wrreq & (~flags.full | rd_ok);

    always_comb begin
        usedw_nxt = usedw;
        if (wr_ok && !rd_ok) begin
            usedw_nxt = usedw + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            usedw_nxt = usedw - CW'(1);
        end
    end

    // Flags are registered from the next count so they line up with usedw.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            usedw     <= '0;
            flags     <= FLAGS_CLR;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (sclr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            usedw     <= '0;
            flags     <= FLAGS_CLR;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            usedw <= usedw_nxt;
            flags <= decode_flags(32'(usedw_nxt), DEPTH, ALMOST_FULL_VAL, ALMOST_EMPTY_VAL);
            if (wrreq && flags.full && !rdreq) begin
                overflow <= 1'b1;
            end
            if (rdreq && flags.empty) begin
                underflow <= 1'b1;
            end
        end
    end

    assign empty        = flags.empty;
    assign full         = flags.full;
    assign almost_empty = flags.almost_empty;
    assign almost_full  = flags.almost_full;

    param_scfifo_dpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dpram (
        .clock (clock),
        .we    (wr_ok & ~sclr),
        .waddr (wr_ptr),
        .wdata (data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    generate
        if (SHOW_AHEAD == SHOW_AHEAD_ON) begin : g_show_ahead
            // Head word is presented directly; meaningless while empty.
            assign q = rdata;
        end else begin : g_normal
            always_ff @(posedge clock or posedge aclr) begin
                if (aclr) begin
                    q <= '0;
                end else if (sclr) begin
                    q <= '0;
                end else if (rd_ok) begin
                    q <= rdata;
                end
            end
        end
    endgenerate

endmodule
